// File: rtl/md_sched.sv
// Multiply/divide scheduler owning HI/LO: latches operands on issue, counts down the op latency, commits once.
// Latency: MULT*/DIV* commit MULT_LAT/DIV_LAT edges after issue; MTHI/MTLO write on the issuing edge.
// Backpressure: stall to D while busy or while an MD op issues from E; a start seen while busy is dropped.
module md_sched #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        d_md,
    output logic        busy,
    output logic        stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [31:0]     r_a;
    logic [31:0]     r_b;
    logic            r_sgn;
    logic [31:0]     r_hi;
    logic [31:0]     r_lo;

    logic            w_op_mul;
    logic            w_op_div;
    logic [63:0]     w_a64;
    logic [63:0]     w_b64;
    logic [63:0]     w_prod;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [31:0]     w_ua;
    logic [31:0]     w_ub;
    logic [31:0]     w_ub_nz;
    logic [31:0]     w_uq;
    logic [31:0]     w_ur;
    logic [31:0]     w_q;
    logic [31:0]     w_r;
    logic            w_div_zero;

    assign w_op_mul = (op[2:1] == 2'b00);
    assign w_op_div = (op[2:1] == 2'b01);

    // Sign-extending only for signed ops lets one 64-bit multiply serve MULT and MULTU.
    assign w_a64  = {{32{r_sgn & r_a[31]}}, r_a};
    assign w_b64  = {{32{r_sgn & r_b[31]}}, r_b};
    assign w_prod = w_a64 * w_b64;

    // Divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000 with no overflow corner.
    assign w_a_neg    = r_sgn & r_a[31];
    assign w_b_neg    = r_sgn & r_b[31];
    assign w_ua       = w_a_neg ? (32'd0 - r_a) : r_a;
    assign w_ub       = w_b_neg ? (32'd0 - r_b) : r_b;
    assign w_div_zero = (r_b == 32'd0);
    assign w_ub_nz    = w_div_zero ? 32'd1 : w_ub;
    assign w_uq       = w_ua / w_ub_nz;
    assign w_ur       = w_ua % w_ub_nz;
    assign w_q        = (w_a_neg ^ w_b_neg) ? (32'd0 - w_uq) : w_uq;
    assign w_r        = w_a_neg ? (32'd0 - w_ur) : w_ur;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start && w_op_mul) begin
                    w_state_nxt = S_MUL;
                end else if (start && w_op_div) begin
                    w_state_nxt = S_DIV;
                end
            end
            S_MUL, S_DIV: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_sgn <= 1'b0;
            r_hi  <= '0;
            r_lo  <= '0;
        end else if (r_state == S_IDLE) begin
            if (start) begin
                case (op)
                    3'd0, 3'd1: begin
                        r_a   <= A;
                        r_b   <= B;
                        r_sgn <= ~op[0];
                        r_cnt <= CW'(MULT_LAT - 1);
                    end
                    3'd2, 3'd3: begin
                        r_a   <= A;
                        r_b   <= B;
                        r_sgn <= ~op[0];
                        r_cnt <= CW'(DIV_LAT - 1);
                    end
                    3'd4:    r_hi <= A;
                    3'd5:    r_lo <= A;
                    default: ;
                endcase
            end
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
        end else if (r_state == S_MUL) begin
            r_hi <= w_prod[63:32];
            r_lo <= w_prod[31:0];
        end else if (!w_div_zero) begin
            r_hi <= w_r;
            r_lo <= w_q;
        end
    end

    assign busy  = (r_state != S_IDLE);
    assign stall = d_md & (busy | (start & ~op[2]));
    assign HI    = r_hi;
    assign LO    = r_lo;

endmodule

// File: tb/tb_md_sched.sv
// Directed plus randomized bench for md_sched against an arithmetic HI/LO reference model.
module tb_md_sched;

    localparam int ML = 5;
    localparam int DL = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        d_md;
    logic        busy;
    logic        stall;
    logic [31:0] HI;
    logic [31:0] LO;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    md_sched #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .d_md  (d_md),
        .busy  (busy),
        .stall (stall),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Architectural meaning of each op, in plain 64-bit arithmetic.
    task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint p;
        longint q;
        longint r;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            3'd0: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
            3'd1: begin up = {32'd0, a} * {32'd0, b}; m_hi = up[63:32]; m_lo = up[31:0]; end
            3'd2: if (b != 0) begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
            3'd3: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
            3'd4: m_hi = a;
            3'd5: m_lo = a;
            default: ;
        endcase
    endtask

    // Called at a negedge; returns at the first negedge with busy low so the next issue is back-to-back.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic dm, input bit inject);
        int cyc;
        int lat;
        d_md  = dm;
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        #1;
        chk("stall_issue", {63'd0, stall}, {63'd0, dm & (o <= 3'd3)});
        @(negedge clk);
        start = 1'b0;
        A     = $urandom;
        B     = $urandom;
        if (o <= 3'd3) begin
            lat = (o <= 3'd1) ? ML : DL;
            cyc = 0;
            while (busy === 1'b1 && cyc < 60) begin
                chk("stall_busy", {63'd0, stall}, {63'd0, dm});
                chk("hold_hi", {32'd0, HI}, {32'd0, m_hi});
                chk("hold_lo", {32'd0, LO}, {32'd0, m_lo});
                if (inject && cyc == 1) begin
                    start = 1'b1;
                    op    = 3'($urandom_range(0, 5));
                    A     = $urandom;
                    B     = $urandom;
                end
                @(negedge clk);
                start = 1'b0;
                cyc++;
            end
            chk("busy_len", 64'(cyc), 64'(lat));
        end else begin
            chk("busy_mt", {63'd0, busy}, 64'd0);
        end
        model(o, a, b);
        chk("hi", {32'd0, HI}, {32'd0, m_hi});
        chk("lo", {32'd0, LO}, {32'd0, m_lo});
        chk("stall_after", {63'd0, stall}, 64'd0);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        op    = 3'd0;
        A     = 32'd0;
        B     = 32'd0;
        d_md  = 1'b1;
        #1;
        chk("rst_hi", {32'd0, HI}, 64'd0);
        chk("rst_lo", {32'd0, LO}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_stall", {63'd0, stall}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        run_op(3'd0, 32'hFFFFFFFF, 32'd2, 1'b1, 1'b0);
        chk("mult_hi_const", {32'd0, HI}, 64'hFFFFFFFF);
        chk("mult_lo_const", {32'd0, LO}, 64'hFFFFFFFE);
        run_op(3'd1, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b0);
        chk("multu_hi_const", {32'd0, HI}, 64'h00000001);
        chk("multu_lo_const", {32'd0, LO}, 64'hFFFFFFFE);
        run_op(3'd2, 32'hFFFFFFF9, 32'd2, 1'b1, 1'b0);
        chk("div_lo_const", {32'd0, LO}, 64'hFFFFFFFD);
        chk("div_hi_const", {32'd0, HI}, 64'hFFFFFFFF);
        run_op(3'd3, 32'd7, 32'd2, 1'b0, 1'b0);
        chk("divu_lo_const", {32'd0, LO}, 64'd3);
        chk("divu_hi_const", {32'd0, HI}, 64'd1);
        run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
        chk("divovf_lo_const", {32'd0, LO}, 64'h80000000);
        chk("divovf_hi_const", {32'd0, HI}, 64'd0);

        run_op(3'd4, 32'h11, 32'h0, 1'b1, 1'b0);
        run_op(3'd5, 32'h22, 32'h0, 1'b1, 1'b0);
        run_op(3'd3, 32'd1234, 32'd0, 1'b1, 1'b0);
        chk("dz_hi_const", {32'd0, HI}, 64'h11);
        chk("dz_lo_const", {32'd0, LO}, 64'h22);

        run_op(3'd0, 32'd3, 32'd4, 1'b1, 1'b1);
        chk("b2b_mul_lo", {32'd0, LO}, 64'd12);
        chk("b2b_mul_hi", {32'd0, HI}, 64'd0);
        run_op(3'd2, 32'd20, 32'd6, 1'b1, 1'b1);
        chk("b2b_div_lo", {32'd0, LO}, 64'd3);
        chk("b2b_div_hi", {32'd0, HI}, 64'd2);

        run_op(3'd6, 32'hDEADBEEF, 32'h1, 1'b1, 1'b0);
        run_op(3'd7, 32'hCAFEF00D, 32'h2, 1'b1, 1'b0);

        // Abort a divide in flight with an asynchronous reset pulse.
        run_op(3'd4, 32'h55, 32'h0, 1'b0, 1'b0);
        d_md  = 1'b1;
        start = 1'b1;
        op    = 3'd2;
        A     = 32'd100;
        B     = 32'd7;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_hi", {32'd0, HI}, 64'd0);
        chk("abort_lo", {32'd0, LO}, 64'd0);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_stall", {63'd0, stall}, 64'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk("post_abort_busy", {63'd0, busy}, 64'd0);
            chk("post_abort_hi", {32'd0, HI}, 64'd0);
            chk("post_abort_lo", {32'd0, LO}, 64'd0);
        end

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  ro;
            logic [31:0] ra;
            logic [31:0] rb;
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
            run_op(ro, ra, rb, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
